// File: rtl/cred_engine.sv
// Credential datapath: tag table, flash sequencing and shared-AES handshake under one FSM.
// Define ZEROIZE_EN to add the zeroize input that wipes sensitive state in any state.
module cred_engine #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] LOCAL_KEY = '0
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef ZEROIZE_EN
  input  logic                      zeroize,
`endif
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [DATA_WIDTH-1:0]     cmd_account,
  input  logic [DATA_WIDTH-1:0]     cmd_pass,
  input  logic [DATA_WIDTH-1:0]     master_key,
  output logic                      rsp_valid,
  output logic [1:0]                rsp_status,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [ADDR_WIDTH-1:0]     rsp_slot,
  output logic                      fl_rd_req,
  input  logic                      fl_rd_valid,
  input  logic [2*DATA_WIDTH-1:0]   fl_rdata,
  output logic                      fl_wr_req,
  input  logic                      fl_wr_ack,
  output logic [ADDR_WIDTH-1:0]     fl_addr,
  output logic [2*DATA_WIDTH-1:0]   fl_wdata,
  output logic                      aes_start,
  output logic                      aes_decrypt,
  output logic [DATA_WIDTH-1:0]     aes_key,
  output logic [DATA_WIDTH-1:0]     aes_din,
  input  logic                      aes_done,
  input  logic [DATA_WIDTH-1:0]     aes_dout
);
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [3:0] S_IDLE = 4'd0, S_BOOT_RD = 4'd1, S_BOOT_WAIT = 4'd2, S_MATCH = 4'd3,
                         S_RD_REQ = 4'd4, S_RD_WAIT = 4'd5, S_DEC = 4'd6, S_ENC = 4'd7,
                         S_WR_REQ = 4'd8, S_WR_WAIT = 4'd9, S_DONE = 4'd10;
  localparam logic [1:0] OP_BOOT = 2'd0, OP_STORE = 2'd1, OP_LOOKUP = 2'd2;
  localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2, ST_BADOP = 2'd3;

  logic zeroize_w;
`ifdef ZEROIZE_EN
  assign zeroize_w = zeroize;
`else
  assign zeroize_w = 1'b0;
`endif

  logic [3:0]            state_q, state_d;
  logic [1:0]            op_q, op_d, status_q, status_d;
  logic [DW-1:0]         acct_q, acct_d, pass_q, pass_d, master_q, master_d, work_q, work_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, slot_q, slot_d;
  logic                  aes_busy_q, aes_busy_d;
  logic [DW-1:0]         tag_q [DEPTH];
  logic [DW-1:0]         tag_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [DW-1:0]         rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] rsp_slot_q, rsp_slot_d;

  logic                  hit_found, free_found;
  logic [ADDR_WIDTH-1:0] hit_idx, free_idx;

  // Parallel tag compare; descending scan leaves the lowest index as the winner.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == acct_q) && (acct_q != '0)) begin
        hit_found = 1'b1;
        hit_idx   = ADDR_WIDTH'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = ADDR_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    status_d     = status_q;
    acct_d       = acct_q;
    pass_d       = pass_q;
    master_d     = master_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    aes_busy_d   = aes_busy_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    rsp_slot_d   = rsp_slot_q;
    case (state_q)
      S_IDLE: begin
        aes_busy_d = 1'b0;
        if (cmd_valid) begin
          op_d     = cmd_op;
          acct_d   = cmd_account;
          pass_d   = cmd_pass;
          master_d = master_key;
          case (cmd_op)
            OP_BOOT:             begin cnt_d = '0; state_d = S_BOOT_RD; end
            OP_STORE, OP_LOOKUP: state_d = S_MATCH;
            default:             begin status_d = ST_BADOP; slot_d = '0; state_d = S_DONE; end
          endcase
        end
      end
      S_BOOT_RD: state_d = S_BOOT_WAIT;
      S_BOOT_WAIT: if (fl_rd_valid) begin
        tag_d[cnt_q]   = fl_rdata[2*DW-1:DW];
        valid_d[cnt_q] = (fl_rdata[2*DW-1:DW] != '0);
        if (&cnt_q) begin
          status_d = ST_OK;
          slot_d   = cnt_q;
          state_d  = S_DONE;
        end else begin
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
          state_d = S_BOOT_RD;
        end
      end
      S_MATCH: begin
        slot_d = '0;
        if (hit_found) begin
          slot_d  = hit_idx;
          state_d = (op_q == OP_LOOKUP) ? S_RD_REQ : S_ENC;
        end else if (op_q == OP_LOOKUP) begin
          status_d = ST_MISS;
          state_d  = S_DONE;
        end else if (free_found) begin
          slot_d  = free_idx;
          state_d = S_ENC;
        end else begin
          status_d = ST_FULL;
          state_d  = S_DONE;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: if (fl_rd_valid) begin
        work_d  = fl_rdata[DW-1:0];
        state_d = S_DEC;
      end
      S_DEC: begin
        if (!aes_busy_q) aes_busy_d = 1'b1;
        else if (aes_done) begin
          work_d     = aes_dout;
          aes_busy_d = 1'b0;
          state_d    = S_ENC;
        end
      end
      S_ENC: begin
        if (!aes_busy_q) aes_busy_d = 1'b1;
        else if (aes_done) begin
          work_d     = aes_dout;
          aes_busy_d = 1'b0;
          status_d   = ST_OK;
          state_d    = (op_q == OP_LOOKUP) ? S_DONE : S_WR_REQ;
        end
      end
      S_WR_REQ, S_WR_WAIT: begin
        if (fl_wr_ack) begin
          tag_d[slot_q]   = acct_q;
          valid_d[slot_q] = 1'b1;
          status_d        = ST_OK;
          state_d         = S_DONE;
        end else begin
          state_d = S_WR_WAIT;
        end
      end
      S_DONE: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = status_q;
        rsp_slot_d   = slot_q;
        rsp_data_d   = (op_q == OP_LOOKUP && status_q == ST_OK) ? work_q : '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Zeroize wins over any handshake strobe seen in the same cycle.
    if (zeroize_w) begin
      state_d     = S_IDLE;
      valid_d     = '0;
      for (int i = 0; i < DEPTH; i++) tag_d[i] = '0;
      master_d    = '0;
      pass_d      = '0;
      work_d      = '0;
      rsp_data_d  = '0;
      aes_busy_d  = 1'b0;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      status_q     <= '0;
      acct_q       <= '0;
      pass_q       <= '0;
      master_q     <= '0;
      work_q       <= '0;
      cnt_q        <= '0;
      slot_q       <= '0;
      aes_busy_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      valid_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      rsp_slot_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      status_q     <= status_d;
      acct_q       <= acct_d;
      pass_q       <= pass_d;
      master_q     <= master_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      aes_busy_q   <= aes_busy_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      rsp_slot_q   <= rsp_slot_d;
    end
  end

  logic wr_phase, enc_lookup;
  assign wr_phase   = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
  assign enc_lookup = (op_q == OP_LOOKUP);

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_slot    = rsp_slot_q;
  assign fl_rd_req   = (state_q == S_BOOT_RD) || (state_q == S_RD_REQ);
  assign fl_wr_req   = wr_phase && !zeroize_w;
  assign fl_addr     = ((state_q == S_BOOT_RD) || (state_q == S_BOOT_WAIT)) ? cnt_q :
                       ((state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || wr_phase) ? slot_q : '0;
  assign fl_wdata    = wr_phase ? {acct_q, work_q} : '0;
  // Key/din are pure functions of state and held registers, so they stay put until aes_done.
  assign aes_start   = ((state_q == S_DEC) || (state_q == S_ENC)) && !aes_busy_q;
  assign aes_decrypt = (state_q == S_DEC);
  assign aes_key     = (state_q == S_DEC) ? LOCAL_KEY :
                       (state_q == S_ENC) ? (enc_lookup ? master_q : LOCAL_KEY) : '0;
  assign aes_din     = (state_q == S_DEC) ? work_q :
                       (state_q == S_ENC) ? (enc_lookup ? work_q : pass_q) : '0;
endmodule

// File: doc/cred_engine.md
Name: cred_engine

Overview:
- Parametrised, self-sequencing credential datapath.
- Holds a DEPTH-entry account tag table (parallel match) and sequences flash read/write plus an external shared AES core through a handshake.
- Serves three host commands: BOOT (load tags from flash), STORE (encrypt a password with the local key and write it to flash), LOOKUP (read, decrypt with the local key, re-encrypt with the master key, return).
- Replaces the externally strobed register/mux control of the previous credential datapath with an internal FSM; sits between the host command interface, the flash controller and the AES wrapper.

Parameters:
- DATA_WIDTH, 128, width of account tag, password, key and cipher block.
- ADDR_WIDTH, 4, flash slot address width; DEPTH = 2**ADDR_WIDTH table entries.
- LOCAL_KEY, 128'h0, device-local storage key (DATA_WIDTH bits).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=BOOT, 1=STORE, 2=LOOKUP, 3=reserved
- cmd_account  in  DATA_WIDTH  account tag
- cmd_pass  in  DATA_WIDTH  plaintext password (STORE)
- master_key  in  DATA_WIDTH  host master key, sampled at command accept
- rsp_valid  out  1  one-cycle response strobe
- rsp_status  out  2  0=OK, 1=MISS, 2=FULL, 3=BADOP
- rsp_data  out  DATA_WIDTH  LOOKUP result; 0 otherwise
- rsp_slot  out  ADDR_WIDTH  slot used/found
- fl_rd_req  out  1  flash read pulse
- fl_rd_valid  in  1  read data valid
- fl_rdata  in  2*DATA_WIDTH  read data {account, cipher}
- fl_wr_req  out  1  write request, held until ack
- fl_wr_ack  in  1  write complete
- fl_addr  out  ADDR_WIDTH  flash slot address
- fl_wdata  out  2*DATA_WIDTH  write data {account, cipher}
- aes_start  out  1  one-cycle start
- aes_decrypt  out  1  1=decrypt, 0=encrypt
- aes_key  out  DATA_WIDTH  key
- aes_din  out  DATA_WIDTH  input block
- aes_done  in  1  output valid pulse
- aes_dout  in  DATA_WIDTH  result

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0 except cmd_ready=1; tag table and valid bits cleared. Any in-flight flash or AES transaction is abandoned; late fl_rd_valid, fl_wr_ack or aes_done strobes arriving in IDLE are ignored.
- Accept: cmd_valid & cmd_ready latches cmd_op, cmd_account, cmd_pass and master_key into internal registers, then leaves IDLE.
- Reserved op: next cycle goes to DONE with BADOP.
- States: IDLE, BOOT_RD, BOOT_WAIT, MATCH, RD_REQ, RD_WAIT, DEC, ENC, WR_REQ, WR_WAIT, DONE.
- BOOT:
  - For slot i = 0..DEPTH-1: BOOT_RD pulses fl_rd_req with fl_addr=i, then BOOT_WAIT waits for fl_rd_valid.
  - Stores tag = fl_rdata[2*DATA_WIDTH-1:DATA_WIDTH]; valid = (tag != 0).
  - After slot DEPTH-1: DONE with OK, rsp_slot = DEPTH-1. The slot counter must not wrap early.
- MATCH (1 cycle):
  - Registered parallel compare of the latched account against all valid tags; lowest-index hit wins.
  - Also records the lowest-index free slot.
  - An all-zero account never matches.
- LOOKUP:
  - Miss: DONE with MISS.
  - Hit: RD_REQ at the hit slot, then RD_WAIT latches the cipher from fl_rdata[DATA_WIDTH-1:0].
  - DEC: aes_start with aes_decrypt=1, key=LOCAL_KEY; wait for aes_done.
  - ENC: aes_start with aes_decrypt=0, key=latched master_key, din=decrypted value; wait for aes_done.
  - DONE: rsp_data=aes_dout, status OK.
- STORE:
  - Target slot is the hit slot if the account exists (overwrite); otherwise the lowest free slot; none free gives DONE with FULL and no flash write.
  - ENC: encrypts the latched password with LOCAL_KEY.
  - WR_REQ: fl_wr_req=1, fl_addr=slot, fl_wdata={account, cipher}, all held stable until fl_wr_ack.
  - On ack: tag[slot]=account, valid[slot]=1; DONE with OK.
- AES handshake:
  - aes_start is exactly one cycle per operation.
  - aes_key and aes_din stay stable from start until aes_done.
  - aes_done in any non-waiting state is ignored.
- DONE: rsp_valid=1 for one cycle; rsp_data, rsp_status and rsp_slot held until the next DONE; returns to IDLE.
- Latency:
  - LOOKUP = 2 + flash read + AES dec + AES enc + 1 cycles.
  - MISS response comes 3 cycles after accept.
- cmd_valid while busy is ignored; commands are never queued.

Optional Feature:
- Macro ZEROIZE_EN.
- Enabled: adds input port zeroize (1 bit).
  - In any state, zeroize clears all valid bits, tags, the latched key/password/cipher registers and rsp_data within one cycle.
  - FSM forces to IDLE with no response strobe; fl_wr_req drops immediately.
  - Has priority over aes_done, fl_rd_valid and fl_wr_ack in the same cycle.
- Disabled: port absent; sensitive data is cleared only by rst.

Test Plan:
- BOOT with flash model: slot 0 = {0x11..11, X}, slot 3 = {0x22..22, Y}, others 0 -> 16 read pulses, OK, rsp_slot=15; valid set only for slots 0 and 3.
- STORE account 0xA5..A5, pass 0x0123..CDEF into empty table -> AES enc with LOCAL_KEY; fl_addr=0, fl_wdata={0xA5..A5, AES(0,pass)}; OK, rsp_slot=0.
- LOOKUP 0xA5..A5, master_key 0x2B7E1516 28AED2A6 ABF71588 09CF4F3C -> decrypt with LOCAL_KEY then encrypt with master key; rsp_data equals golden AES-128 output; slot 0.
- LOOKUP unknown account 0x77..77 -> MISS exactly 3 cycles after accept; no fl_rd_req, no aes_start.
- Fill all 16 slots, STORE new account -> FULL, no fl_wr_req. STORE an existing account -> overwrites its original slot.
- Assert rst while in WR_WAIT, then raise fl_wr_ack 2 cycles later -> outputs at reset values, tag table unchanged by the ack. With ZEROIZE_EN, zeroize during DEC -> IDLE, no rsp_valid, subsequent LOOKUP returns MISS.
